// File: rtl/life_engine.sv
// life_engine: 8x8 Game of Life board, one cell evaluated per clock, atomic commit.
//   clk, reset  : clock, synchronous active-high reset
//   load, seed  : load a board (bit row*8+col), aborts any generation in flight
//   step        : start one generation (accepted only when idle)
//   grid        : committed board
//   busy, done  : generation in progress / one-cycle commit pulse
//   generation  : generations since last load or reset
//   stable      : last commit left the board unchanged
//   extinct     : board is empty
module life_engine #(
  parameter int WRAP = 1,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [63:0]      seed,
  input  logic             step,
  output logic [63:0]      grid,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] generation,
  output logic             stable,
  output logic             extinct
);
  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;
  state_t state, state_next;
  logic [5:0] idx;
  logic [63:0] shadow;
  logic [3:0] n;
  logic nxt;
  // Neighbours are read from the committed grid so the shadow never feeds back.
  function automatic logic cell_at(input logic [63:0] g, input int rr, input int cc);
    logic [5:0] i;
    i = 6'(((rr & 7) << 3) | (cc & 7));
    if (WRAP == 0 && (rr < 0 || rr > 7 || cc < 0 || cc > 7)) return 1'b0;
    return g[i];
  endfunction
  always_comb begin
    n = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0)
          n = n + 4'(cell_at(grid, int'(idx[5:3]) + dr, int'(idx[2:0]) + dc));
    nxt = grid[idx] ? (n == 4'd2 || n == 4'd3) : (n == 4'd3);
  end
  always_comb begin
    state_next = state;
    if (load) state_next = IDLE;
    else if (state == IDLE) state_next = step ? COMPUTE : IDLE;
    else if (state == COMPUTE) state_next = (idx == 6'd63) ? COMMIT : COMPUTE;
    else state_next = IDLE;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      grid <= '0;
      generation <= '0;
      stable <= 1'b0;
      idx <= '0;
      shadow <= '0;
    end else if (load) begin
      grid <= seed;
      generation <= '0;
      stable <= 1'b0;
    end else if (state == IDLE) begin
      if (step) idx <= '0;
    end else if (state == COMPUTE) begin
      shadow[idx] <= nxt;
      idx <= idx + 6'd1;
    end else begin
      grid <= shadow;
      stable <= (shadow == grid);
      generation <= generation + 1'b1;
      done <= 1'b1;
    end
  end
  assign busy = (state != IDLE);
  assign extinct = (grid == '0);
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed checks of life_engine with toroidal and bounded instances.
module tb_life_engine;
  logic clk = 1'b0, reset = 1'b0, load = 1'b0, step = 1'b0;
  logic [63:0] seed = '0;
  logic [63:0] grid, grid0;
  logic busy, done, stable, extinct, busy0, done0, stable0, extinct0;
  logic [15:0] generation, generation0;
  int total = 0, bad = 0, cyc, bc, dc;
  always #5 clk = ~clk;
  life_engine #(.WRAP(1), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step), .grid(grid),
    .busy(busy), .done(done), .generation(generation), .stable(stable), .extinct(extinct));
  life_engine #(.WRAP(0), .GEN_W(16)) dut0 (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step), .grid(grid0),
    .busy(busy0), .done(done0), .generation(generation0), .stable(stable0), .extinct(extinct0));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_load(input logic [63:0] s);
    seed = s;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic run_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 0;
    bc = 0;
    while (!done && cyc < 200) begin
      if (busy) bc++;
      tick();
      cyc++;
    end
  endtask
  initial begin
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_grid", grid, 64'h0);
    chk("rst_gen", 64'(generation), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stable", 64'(stable), 64'd0);
    chk("rst_extinct", 64'(extinct), 64'd1);
    do_load(64'h0000_0000_1C00_0000);
    run_step();
    chk("blk_latency", 64'(cyc), 64'd65);
    chk("blk_busy_cycles", 64'(bc), 64'd65);
    chk("blk_grid1", grid, 64'h0000_0008_0808_0000);
    chk("blk_gen1", 64'(generation), 64'd1);
    chk("blk_stable1", 64'(stable), 64'd0);
    chk("blk_busy_at_done", 64'(busy), 64'd0);
    tick();
    chk("blk_done_one_cycle", 64'(done), 64'd0);
    run_step();
    chk("blk_grid2", grid, 64'h0000_0000_1C00_0000);
    chk("blk_gen2", 64'(generation), 64'd2);
    do_load(64'h0000_0018_1800_0000);
    chk("load_gen_clear", 64'(generation), 64'd0);
    run_step();
    chk("block_grid", grid, 64'h0000_0018_1800_0000);
    chk("block_stable", 64'(stable), 64'd1);
    chk("block_gen", 64'(generation), 64'd1);
    chk("block_extinct", 64'(extinct), 64'd0);
    do_load(64'h0000_0001_0101_0000);
    chk("load_stable_clear", 64'(stable), 64'd0);
    run_step();
    chk("edge_wrap1", grid, 64'h0000_0000_8300_0000);
    chk("edge_wrap0", grid0, 64'h0000_0000_0300_0000);
    chk("edge_done_wrap0", 64'(done0), 64'd1);
    do_load(64'h1);
    run_step();
    chk("lone_grid", grid, 64'h0);
    chk("lone_extinct", 64'(extinct), 64'd1);
    chk("lone_gen", 64'(generation), 64'd1);
    chk("lone_done", 64'(done), 64'd1);
    dc = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (done) dc++;
    end
    chk("lone_done_once", 64'(dc), 64'd0);
    do_load(64'h0000_0000_1C00_0000);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (10) tick();
    do_load(64'hFF);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_grid", grid, 64'hFF);
    chk("abort_gen", 64'(generation), 64'd0);
    dc = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) dc++;
      tick();
    end
    chk("abort_no_done", 64'(dc), 64'd0);
    chk("abort_grid_hold", grid, 64'hFF);
    do_load(64'h0000_0000_1C00_0000);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (5) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("ignored_step_latency", 64'(cyc), 64'd59);
    chk("ignored_step_gen", 64'(generation), 64'd1);
    dc = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done || busy) dc++;
    end
    chk("ignored_step_not_queued", 64'(dc), 64'd0);
    chk("ignored_step_gen_hold", 64'(generation), 64'd1);
    do_load(64'h0000_0000_1C00_0000);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_grid", grid, 64'h0);
    chk("rstmid_gen", 64'(generation), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    seed = 64'h0000_0000_1C00_0000;
    load = 1'b1;
    step = 1'b1;
    tick();
    load = 1'b0;
    step = 1'b0;
    chk("loadstep_grid", grid, 64'h0000_0000_1C00_0000);
    chk("loadstep_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("loadstep_still_idle", 64'(busy), 64'd0);
    chk("loadstep_gen", 64'(generation), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
